// File: rtl/parity_serial_receiver_if.sv
// Bus bundle for the parity-protected serial receiver.
// The master side is the serial line sampler, which drives the bit stream
// and observes the parallel word. The slave side is the receiver itself.
interface parity_serial_receiver_if #(
    parameter int W = 8
);
    logic         serial_valid;
    logic         serial_first;
    logic         serial_data;
    logic         parallel_valid;
    logic [W-1:0] parallel_data;
    logic         parity_err;
    logic         busy;

    modport master (
        output serial_valid,
        output serial_first,
        output serial_data,
        input  parallel_valid,
        input  parallel_data,
        input  parity_err,
        input  busy
    );

    modport slave (
        input  serial_valid,
        input  serial_first,
        input  serial_data,
        output parallel_valid,
        output parallel_data,
        output parity_err,
        output busy
    );
endinterface

// File: rtl/parity_serial_receiver.sv
// Parity-protected serial receiver: gathers W data bits (LSB first) and a
// trailing parity bit, then presents the word in parallel with a one-cycle
// valid pulse and a parity error flag.
// Optional build macro PARITY_DROP_BAD_EN: frames failing the parity check
// only pulse parity_err; parallel_valid stays low and the word is not updated.
module parity_serial_receiver #(
    parameter int W          = 8,
    parameter int ODD_PARITY = 0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    parity_serial_receiver_if.slave   bus
);

    localparam int   CW     = (W > 1) ? $clog2(W) : 1;
    localparam logic LP_ODD = (ODD_PARITY != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_nextState;
    logic [CW-1:0]  r_cnt;
    logic           r_acc;
    logic [W-1:0]   r_shift;
    logic           r_parallelValid;
    logic [W-1:0]   r_parallelData;
    logic           r_parityErr;
    logic           r_busy;

    logic           w_loadFirst;
    logic           w_storeBit;
    logic           w_frameDone;
    logic           w_parityBad;

    // State register; reset returns to IDLE and abandons any partial frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode: a valid first bit always restarts a frame, otherwise
    // valid bits advance DATA -> PARITY -> IDLE and are ignored in IDLE.
    always_comb begin
        w_nextState = r_state;
        w_loadFirst = 1'b0;
        w_storeBit  = 1'b0;
        w_frameDone = 1'b0;
        if (bus.serial_valid) begin
            if (bus.serial_first) begin
                w_loadFirst = 1'b1;
                w_nextState = (W == 1) ? PARITY : DATA;
            end else begin
                case (r_state)
                    DATA: begin
                        w_storeBit = 1'b1;
                        if (r_cnt == CW'(W - 1)) begin
                            w_nextState = PARITY;
                        end
                    end
                    PARITY: begin
                        w_frameDone = 1'b1;
                        w_nextState = IDLE;
                    end
                    default: begin
                        w_nextState = IDLE;
                    end
                endcase
            end
        end
    end

    assign w_parityBad = r_acc ^ bus.serial_data ^ LP_ODD;

    // Datapath: capture bits into the assembly register, accumulate parity,
    // and publish the finished word only when the parity bit arrives.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt           <= '0;
            r_acc           <= 1'b0;
            r_shift         <= '0;
            r_parallelValid <= 1'b0;
            r_parallelData  <= '0;
            r_parityErr     <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_parallelValid <= 1'b0;
            r_busy          <= (w_nextState != IDLE);
`ifdef PARITY_DROP_BAD_EN
            r_parityErr     <= 1'b0;
`endif
            if (w_loadFirst) begin
                r_shift[0] <= bus.serial_data;
                r_acc      <= bus.serial_data;
                r_cnt      <= CW'(1);
            end else if (w_storeBit) begin
                r_shift[r_cnt] <= bus.serial_data;
                r_acc          <= r_acc ^ bus.serial_data;
                r_cnt          <= r_cnt + CW'(1);
            end else if (w_frameDone) begin
                r_cnt <= '0;
                r_acc <= 1'b0;
`ifdef PARITY_DROP_BAD_EN
                if (w_parityBad) begin
                    r_parityErr <= 1'b1;
                end else begin
                    r_parallelValid <= 1'b1;
                    r_parallelData  <= r_shift;
                    r_parityErr     <= 1'b0;
                end
`else
                r_parallelValid <= 1'b1;
                r_parallelData  <= r_shift;
                r_parityErr     <= w_parityBad;
`endif
            end
        end
    end

    assign bus.parallel_valid = r_parallelValid;
    assign bus.parallel_data  = r_parallelData;
    assign bus.parity_err     = r_parityErr;
    assign bus.busy           = r_busy;

endmodule

// File: tb/tb_parity_serial_receiver.sv
// Directed bench for parity_serial_receiver: an even-parity and an
// odd-parity instance share one serial stream and reset.
module tb_parity_serial_receiver;

    logic clk;
    logic rst_n;
    logic sv;
    logic sf;
    logic sd;

    int total;
    int bad;
    int cycle;
    int pulseE;
    int lastPulseCyc;
    int prevPulseCyc;
    logic [7:0] lastPulseData;
    logic [7:0] prevPulseData;
    logic prevValid;
    int consecCount;
    int p0;

    parity_serial_receiver_if #(.W(8)) busE ();
    parity_serial_receiver_if #(.W(8)) busO ();

    assign busE.serial_valid = sv;
    assign busE.serial_first = sf;
    assign busE.serial_data  = sd;
    assign busO.serial_valid = sv;
    assign busO.serial_first = sf;
    assign busO.serial_data  = sd;

    parity_serial_receiver #(.W(8), .ODD_PARITY(0)) dutEven (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busE.slave)
    );

    parity_serial_receiver #(.W(8), .ODD_PARITY(1)) dutOdd (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busO.slave)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle count used to measure the spacing between output pulses.
    always @(posedge clk) begin
        cycle <= cycle + 1;
    end

    // Observe the even instance's pulses away from the active edge.
    always @(negedge clk) begin
        if (busE.parallel_valid) begin
            pulseE        <= pulseE + 1;
            prevPulseCyc  <= lastPulseCyc;
            prevPulseData <= lastPulseData;
            lastPulseCyc  <= cycle;
            lastPulseData <= busE.parallel_data;
            if (prevValid) consecCount <= consecCount + 1;
        end
        prevValid <= busE.parallel_valid;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            sv = 1'b0;
            sf = 1'b0;
            sd = 1'b0;
        end
    endtask

    // Drives bits 0..nBits-1 of a frame; index 8 is the parity bit.
    task automatic applyStimulus(input logic [7:0] val, input logic par, input int nBits, input int maxGap);
        for (int i = 0; i < nBits; i++) begin
            if (i > 0 && maxGap > 0) begin
                repeat ($urandom_range(maxGap, 0)) begin
                    @(negedge clk);
                    sv = 1'b0;
                    sf = 1'($urandom);
                    sd = 1'($urandom);
                end
            end
            @(negedge clk);
            if (i == 1) checkOutput("busy_mid", {31'd0, busE.busy}, 32'd1);
            sv = 1'b1;
            sf = (i == 0);
            sd = (i < 8) ? val[i] : par;
        end
    endtask

    initial begin
        total = 0; bad = 0; cycle = 0; pulseE = 0;
        lastPulseCyc = 0; prevPulseCyc = 0;
        lastPulseData = 8'h00; prevPulseData = 8'h00;
        prevValid = 1'b0; consecCount = 0;
        sv = 1'b0; sf = 1'b0; sd = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", {31'd0, busE.parallel_valid}, 32'd0);
        checkOutput("rst_data",  {24'd0, busE.parallel_data}, 32'd0);
        checkOutput("rst_err",   {31'd0, busE.parity_err}, 32'd0);
        checkOutput("rst_busy",  {31'd0, busE.busy}, 32'd0);
        rst_n = 1'b1;
        idle(2);

        // 0xA5 with correct even parity.
        p0 = pulseE;
        applyStimulus(8'hA5, 1'b0, 9, 0);
        idle(1);
        checkOutput("a5_valid", {31'd0, busE.parallel_valid}, 32'd1);
        checkOutput("a5_data",  {24'd0, busE.parallel_data}, 32'hA5);
        checkOutput("a5_err",   {31'd0, busE.parity_err}, 32'd0);
        checkOutput("a5_busy",  {31'd0, busE.busy}, 32'd0);
        idle(1);
        checkOutput("a5_pulse_end", {31'd0, busE.parallel_valid}, 32'd0);
        idle(2);
        checkOutput("a5_count", pulseE - p0, 32'd1);

        // 0xA5 with wrong parity.
        p0 = pulseE;
        applyStimulus(8'hA5, 1'b1, 9, 0);
        idle(1);
`ifdef PARITY_DROP_BAD_EN
        checkOutput("a5bad_valid", {31'd0, busE.parallel_valid}, 32'd0);
`else
        checkOutput("a5bad_valid", {31'd0, busE.parallel_valid}, 32'd1);
`endif
        checkOutput("a5bad_err",  {31'd0, busE.parity_err}, 32'd1);
        checkOutput("a5bad_data", {24'd0, busE.parallel_data}, 32'hA5);
        idle(1);
`ifdef PARITY_DROP_BAD_EN
        checkOutput("a5bad_err_hold", {31'd0, busE.parity_err}, 32'd0);
`else
        checkOutput("a5bad_err_hold", {31'd0, busE.parity_err}, 32'd1);
`endif

        // 0x0F with wrong parity: shows whether a bad frame updates the word.
        applyStimulus(8'h0F, 1'b1, 9, 0);
        idle(1);
        checkOutput("0fbad_err", {31'd0, busE.parity_err}, 32'd1);
`ifdef PARITY_DROP_BAD_EN
        checkOutput("0fbad_data", {24'd0, busE.parallel_data}, 32'hA5);
`else
        checkOutput("0fbad_data", {24'd0, busE.parallel_data}, 32'h0F);
`endif
        idle(2);

        // 0x01 with parity 1 and random gaps between bits.
        p0 = pulseE;
        applyStimulus(8'h01, 1'b1, 9, 5);
        idle(1);
        checkOutput("gap_valid", {31'd0, busE.parallel_valid}, 32'd1);
        checkOutput("gap_data",  {24'd0, busE.parallel_data}, 32'h01);
        checkOutput("gap_err",   {31'd0, busE.parity_err}, 32'd0);
        idle(3);
        checkOutput("gap_count", pulseE - p0, 32'd1);

        // Odd versus even parity on an all-zero word.
        applyStimulus(8'h00, 1'b1, 9, 0);
        idle(1);
        checkOutput("odd_p1_err",  {31'd0, busO.parity_err}, 32'd0);
        checkOutput("even_p1_err", {31'd0, busE.parity_err}, 32'd1);
        applyStimulus(8'h00, 1'b0, 9, 0);
        idle(1);
        checkOutput("odd_p0_err",  {31'd0, busO.parity_err}, 32'd1);
        checkOutput("even_p0_err", {31'd0, busE.parity_err}, 32'd0);
        checkOutput("even_p0_data", {24'd0, busE.parallel_data}, 32'h00);
        idle(2);

        // Abandoned partial frame followed by a fresh 0x3C frame.
        p0 = pulseE;
        applyStimulus(8'hFF, 1'b0, 4, 0);
        applyStimulus(8'h3C, 1'b0, 9, 0);
        idle(1);
        checkOutput("abandon_data", {24'd0, busE.parallel_data}, 32'h3C);
        checkOutput("abandon_err",  {31'd0, busE.parity_err}, 32'd0);
        idle(3);
        checkOutput("abandon_count", pulseE - p0, 32'd1);

        // Back-to-back frames 0xFF then 0x80 with no idle cycle between.
        p0 = pulseE;
        applyStimulus(8'hFF, 1'b0, 9, 0);
        applyStimulus(8'h80, 1'b1, 9, 0);
        idle(3);
        checkOutput("b2b_count",   pulseE - p0, 32'd2);
        checkOutput("b2b_spacing", lastPulseCyc - prevPulseCyc, 32'd9);
        checkOutput("b2b_first",   {24'd0, prevPulseData}, 32'hFF);
        checkOutput("b2b_second",  {24'd0, lastPulseData}, 32'h80);
        checkOutput("b2b_err",     {31'd0, busE.parity_err}, 32'd0);

        // Reset in the middle of a frame.
        p0 = pulseE;
        applyStimulus(8'h5A, 1'b0, 5, 0);
        @(negedge clk);
        sv = 1'b0; sf = 1'b0; sd = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("mrst_valid", {31'd0, busE.parallel_valid}, 32'd0);
        checkOutput("mrst_data",  {24'd0, busE.parallel_data}, 32'd0);
        checkOutput("mrst_err",   {31'd0, busE.parity_err}, 32'd0);
        checkOutput("mrst_busy",  {31'd0, busE.busy}, 32'd0);
        rst_n = 1'b1;
        idle(3);
        checkOutput("mrst_count", pulseE - p0, 32'd0);
        applyStimulus(8'h96, 1'b0, 9, 0);
        idle(1);
        checkOutput("post_rst_valid", {31'd0, busE.parallel_valid}, 32'd1);
        checkOutput("post_rst_data",  {24'd0, busE.parallel_data}, 32'h96);
        checkOutput("post_rst_err",   {31'd0, busE.parity_err}, 32'd0);
        idle(3);
        checkOutput("no_consecutive", consecCount, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
